// File: rtl/rb_pkg.sv
// Shared register-bank constants and writeback FSM state encoding.
package rb_pkg;

    localparam int unsigned RB_ADDR_W = 4;
    localparam int unsigned RB_DATA_W = 32;
    localparam int unsigned RB_NREGS  = 2 ** RB_ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or above PTR (mod N_REQ).
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N_REQ-1:0] REQ_VALID,
    input  logic [PTR_W-1:0] PTR,
    output logic [N_REQ-1:0] GRANT,
    output logic [PTR_W-1:0] GRANT_IDX,
    output logic             GRANT_ANY
);

    // Rotate search start to PTR and take the first valid requester found.
    always_comb begin
        GRANT     = '0;
        GRANT_IDX = '0;
        GRANT_ANY = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            int unsigned j;
            j = (int'(PTR) + i) % N_REQ;
            if (!GRANT_ANY && REQ_VALID[j]) begin
                GRANT[j]  = 1'b1;
                GRANT_IDX = PTR_W'(j);
                GRANT_ANY = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Register bank write-port owner: post-reset clear sweep, round-robin writeback
// arbitration and a busy scoreboard driving the decode STALL.
// Optional feature macro: RB_WB_FWD_EN (source forwarding from the writeback path).
module regbank_wb_arbiter
    import rb_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = RB_DATA_W,
    parameter int unsigned ADDR_W = RB_ADDR_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [N_REQ-1:0]         REQ_VALID,
    input  logic [N_REQ*ADDR_W-1:0]  REQ_ADDR,
    input  logic [N_REQ*DATA_W-1:0]  REQ_DATA,
    output logic [N_REQ-1:0]         REQ_READY,
    input  logic                     ISS_VALID,
    input  logic                     ISS_WE,
    input  logic [ADDR_W-1:0]        ISS_RD,
    input  logic [ADDR_W-1:0]        ISS_RA,
    input  logic [ADDR_W-1:0]        ISS_RB,
    output logic                     STALL,
    output logic                     INIT_DONE,
`ifdef RB_WB_FWD_EN
    output logic                     FWD_HIT_A,
    output logic                     FWD_HIT_B,
    output logic [DATA_W-1:0]        FWD_DATA_A,
    output logic [DATA_W-1:0]        FWD_DATA_B,
`endif
    output logic [ADDR_W-1:0]        WC,
    output logic [DATA_W-1:0]        WPC,
    output logic                     W_RB,
    output logic [2**ADDR_W-1:0]     BUSY
);

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    rb_state_e               state_q, state_d;
    logic [ADDR_W:0]         clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]       wc_q, wc_d;
    logic [DATA_W-1:0]       wpc_q, wpc_d;
    logic                    wrb_q, wrb_d;
    logic [NREGS-1:0]        busy_q, busy_d;

    logic [N_REQ-1:0]        grant;
    logic [PTR_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    run;
    logic                    xfer;
    logic                    issue;
    logic [ADDR_W-1:0]       xfer_addr;
    logic [DATA_W-1:0]       xfer_data;
    logic                    src_a_busy, src_b_busy;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .REQ_VALID (REQ_VALID),
        .PTR       (rr_ptr_q),
        .GRANT     (grant),
        .GRANT_IDX (grant_idx),
        .GRANT_ANY (grant_any)
    );

    assign run       = (state_q == ST_RUN);
    assign xfer      = run & grant_any;
    assign REQ_READY = run ? grant : '0;
    assign INIT_DONE = run;
    assign WC        = wc_q;
    assign WPC       = wpc_q;
    assign W_RB      = wrb_q;
    assign BUSY      = busy_q;

    // Select the granted requester's address and data (grant is one-hot).
    always_comb begin
        xfer_addr = '0;
        xfer_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                xfer_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
                xfer_data = REQ_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef RB_WB_FWD_EN
    // Forward a source from this cycle's transfer, else from the bank write in flight.
    always_comb begin
        FWD_HIT_A  = 1'b0;
        FWD_HIT_B  = 1'b0;
        FWD_DATA_A = '0;
        FWD_DATA_B = '0;
        if (xfer && xfer_addr == ISS_RA) begin
            FWD_HIT_A  = 1'b1;
            FWD_DATA_A = xfer_data;
        end else if (run && wrb_q && wc_q == ISS_RA) begin
            FWD_HIT_A  = 1'b1;
            FWD_DATA_A = wpc_q;
        end
        if (xfer && xfer_addr == ISS_RB) begin
            FWD_HIT_B  = 1'b1;
            FWD_DATA_B = xfer_data;
        end else if (run && wrb_q && wc_q == ISS_RB) begin
            FWD_HIT_B  = 1'b1;
            FWD_DATA_B = wpc_q;
        end
    end

    assign src_a_busy = busy_q[ISS_RA] & ~(xfer && xfer_addr == ISS_RA);
    assign src_b_busy = busy_q[ISS_RB] & ~(xfer && xfer_addr == ISS_RB);
`else
    assign src_a_busy = busy_q[ISS_RA];
    assign src_b_busy = busy_q[ISS_RB];
`endif

    assign STALL = ~run | src_a_busy | src_b_busy | (ISS_WE & busy_q[ISS_RD]);
    assign issue = ISS_VALID & ISS_WE & ~STALL;

    // Next-state: clear sweep, then one granted writeback per cycle plus scoreboard update.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        wc_d      = wc_q;
        wpc_d     = wpc_q;
        wrb_d     = 1'b0;
        busy_d    = busy_q;
        unique case (state_q)
            ST_CLEAR: begin
                wrb_d     = 1'b1;
                wc_d      = clr_cnt_q[ADDR_W-1:0];
                wpc_d     = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == (ADDR_W+1)'(NREGS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    wrb_d    = 1'b1;
                    wc_d     = xfer_addr;
                    wpc_d    = xfer_data;
                    rr_ptr_d = PTR_W'((int'(grant_idx) + 1) % N_REQ);
                    busy_d[xfer_addr] = 1'b0;
                end
                // Applied after the clear so a same-index issue keeps the bit set.
                if (issue) begin
                    busy_d[ISS_RD] = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // State and output registers; reset restarts the clear sweep.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
            wc_q      <= '0;
            wpc_q     <= '0;
            wrb_q     <= 1'b0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            wc_q      <= wc_d;
            wpc_q     <= wpc_d;
            wrb_q     <= wrb_d;
            busy_q    <= busy_d;
        end
    end

endmodule
